// File: rtl/wordle_guess_entry_pkg.sv
// Shared constants, state encoding and letter-wrap helpers for the Wordle guess path.
package wordle_guess_entry_pkg;

    localparam int unsigned N_LETTERS = 5;
    localparam int unsigned LW        = 5;

    localparam logic [LW-1:0] LTR_BLANK = LW'(0);
    localparam logic [LW-1:0] LTR_A     = LW'(1);
    localparam logic [LW-1:0] LTR_Z     = LW'(26);

    typedef enum logic {
        StEntry = 1'b0,
        StPend  = 1'b1
    } entry_state_e;

    // Blank and Z both step up to A.
    function automatic logic [LW-1:0] ltr_up(input logic [LW-1:0] l);
        return (l >= LTR_Z || l == LTR_BLANK) ? LTR_A : l + LW'(1);
    endfunction

    // Blank and A both step down to Z.
    function automatic logic [LW-1:0] ltr_dn(input logic [LW-1:0] l);
        return (l == LTR_BLANK || l == LTR_A) ? LTR_Z : l - LW'(1);
    endfunction

endpackage

// File: rtl/wordle_letter_ctr.sv
// One guess letter: blank or A..Z, stepped up/down with wrap, cleared synchronously.
module wordle_letter_ctr
    import wordle_guess_entry_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          clr_i,
    output logic [LW-1:0] letter_o
);

    logic [LW-1:0] letter_q, letter_d;

    // Next letter: clear wins; inc and dec together cancel.
    always_comb begin
        letter_d = letter_q;
        if (clr_i) begin
            letter_d = LTR_BLANK;
        end else if (en_i && inc_i && !dec_i) begin
            letter_d = ltr_up(letter_q);
        end else if (en_i && dec_i && !inc_i) begin
            letter_d = ltr_dn(letter_q);
        end
    end

    // Letter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            letter_q <= LTR_BLANK;
        end else begin
            letter_q <= letter_d;
        end
    end

    assign letter_o = letter_q;

endmodule

// File: rtl/wordle_guess_entry.sv
// Guess entry: cursor, per-letter editing, completeness check and valid/ready hand-off.
module wordle_guess_entry
    import wordle_guess_entry_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    u_i,
    input  logic                    d_i,
    input  logic                    l_i,
    input  logic                    r_i,
    input  logic                    c_i,
    input  logic                    enable_i,
    input  logic                    new_game_i,
    input  logic                    guess_ready_i,
    output logic [N_LETTERS*LW-1:0] guess_word_o,
    output logic                    guess_valid_o,
    output logic [2:0]              cursor_o,
    output logic [LW-1:0]           cur_letter_o,
    output logic                    incomplete_o
);

    localparam logic [2:0] CURSOR_MAX = 3'(N_LETTERS - 1);

    entry_state_e state_q, state_d;
    logic [2:0]   cursor_q, cursor_d;
    logic         incomplete_q, incomplete_d;

    logic [LW-1:0]        letter [N_LETTERS];
    logic [N_LETTERS-1:0] letter_nz;
    logic                 complete;
    logic                 clr, act_lr, act_ud;

    for (genvar i = 0; i < N_LETTERS; i++) begin : g_letter
        wordle_letter_ctr u_letter (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (cursor_q == 3'(i)),
            .inc_i    (act_ud && u_i),
            .dec_i    (act_ud && d_i),
            .clr_i    (clr),
            .letter_o (letter[i])
        );
        assign letter_nz[i]                = |letter[i];
        assign guess_word_o[LW*i +: LW]    = letter[i];
    end

    assign complete = &letter_nz;

    // FSM next state plus edit decode; priority new_game > C > L/R > U/D.
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        incomplete_d = 1'b0;
        clr          = 1'b0;
        act_lr       = 1'b0;
        act_ud       = 1'b0;
        if (new_game_i) begin
            clr      = 1'b1;
            cursor_d = 3'd0;
            state_d  = StEntry;
        end else begin
            unique case (state_q)
                StEntry: begin
                    if (enable_i) begin
                        if (c_i) begin
                            if (complete) begin
                                state_d = StPend;
                            end else begin
                                incomplete_d = 1'b1;
                            end
                        end else if (l_i || r_i) begin
                            act_lr = 1'b1;
                        end else if (u_i || d_i) begin
                            act_ud = 1'b1;
                        end
                    end
                end
                StPend: begin
                    if (guess_ready_i) begin
                        clr      = 1'b1;
                        cursor_d = 3'd0;
                        state_d  = StEntry;
                    end
                end
                default: state_d = StEntry;
            endcase
        end
        if (act_lr) begin
            if (l_i && !r_i && cursor_q != 3'd0) begin
                cursor_d = cursor_q - 3'd1;
            end else if (r_i && !l_i && cursor_q != CURSOR_MAX) begin
                cursor_d = cursor_q + 3'd1;
            end
        end
    end

    // State, cursor and reject-pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StEntry;
            cursor_q     <= 3'd0;
            incomplete_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            incomplete_q <= incomplete_d;
        end
    end

    // Letter under the cursor for the display path.
    always_comb begin
        cur_letter_o = LTR_BLANK;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (cursor_q == 3'(i)) begin
                cur_letter_o = letter[i];
            end
        end
    end

    // guess_valid is the registered PEND state itself.
    assign guess_valid_o = (state_q == StPend);
    assign cursor_o      = cursor_q;
    assign incomplete_o  = incomplete_q;

endmodule

// File: tb/tb_wordle_guess_entry.sv
// Directed bench for wordle_guess_entry with hand-computed expectations.
module tb_wordle_guess_entry;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        u_i = 0, d_i = 0, l_i = 0, r_i = 0, c_i = 0;
    logic        enable_i = 0, new_game_i = 0, guess_ready_i = 0;
    logic [24:0] guess_word_o;
    logic        guess_valid_o;
    logic [2:0]  cursor_o;
    logic [4:0]  cur_letter_o;
    logic        incomplete_o;

    int total = 0;
    int bad   = 0;

    localparam logic [24:0] CRANE = 25'd3 | (25'd18 << 5) | (25'd1 << 10) | (25'd14 << 15)
                                  | (25'd5 << 20);
    localparam logic [24:0] HOLE2 = 25'd1 | (25'd1 << 5) | (25'd1 << 15) | (25'd1 << 20);
    localparam logic [24:0] AAAAA = HOLE2 | (25'd1 << 10);

    wordle_guess_entry dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .u_i           (u_i),
        .d_i           (d_i),
        .l_i           (l_i),
        .r_i           (r_i),
        .c_i           (c_i),
        .enable_i      (enable_i),
        .new_game_i    (new_game_i),
        .guess_ready_i (guess_ready_i),
        .guess_word_o  (guess_word_o),
        .guess_valid_o (guess_valid_o),
        .cursor_o      (cursor_o),
        .cur_letter_o  (cur_letter_o),
        .incomplete_o  (incomplete_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold the given buttons for one rising edge, then sample 1 ns later.
    task automatic step(input logic u, input logic d, input logic l, input logic r,
                        input logic c);
        u_i = u; d_i = d; l_i = l; r_i = r; c_i = c;
        @(posedge clk_i);
        #1;
        u_i = 0; d_i = 0; l_i = 0; r_i = 0; c_i = 0;
    endtask

    task automatic press_u(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        check("rst_word", guess_word_o, 0);
        check("rst_cursor", cursor_o, 0);
        check("rst_valid", guess_valid_o, 0);
        check("rst_incomplete", incomplete_o, 0);
        check("rst_cur_letter", cur_letter_o, 0);
        #5 rst_ni = 1'b1;
        enable_i = 1'b1;
        @(posedge clk_i); #1;

        press_u(3);
        check("3u_word", guess_word_o, 3);
        check("3u_cursor", cursor_o, 0);
        check("3u_valid", guess_valid_o, 0);
        check("3u_cur_letter", cur_letter_o, 3);

        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        check("d_blank_z", guess_word_o, 3 | (26 << 5));
        check("d_cur_letter", cur_letter_o, 26);
        step(1, 0, 0, 0, 0);
        check("u_z_a", guess_word_o, 3 | (1 << 5));
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("l_sat_0", cursor_o, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0);
        check("r_sat_4", cursor_o, 4);

        step(0, 0, 0, 0, 0);
        new_game_i = 1; step(0, 0, 0, 0, 0); new_game_i = 0;
        check("ng_word", guess_word_o, 0);
        check("ng_cursor", cursor_o, 0);

        // CRANE
        press_u(3);  step(0, 0, 0, 1, 0);
        press_u(18); step(0, 0, 0, 1, 0);
        press_u(1);  step(0, 0, 0, 1, 0);
        press_u(14); step(0, 0, 0, 1, 0);
        press_u(5);
        check("crane_word", guess_word_o, CRANE);
        check("crane_valid_pre", guess_valid_o, 0);
        step(0, 0, 0, 0, 1);
        check("crane_valid", guess_valid_o, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("pend_word", guess_word_o, CRANE);
        check("pend_cursor", cursor_o, 4);
        enable_i = 0;
        step(0, 0, 0, 0, 0);
        check("pend_valid_en_low", guess_valid_o, 1);
        enable_i = 1;
        step(0, 0, 0, 0, 0);
        check("pend_valid_4", guess_valid_o, 1);
        guess_ready_i = 1; step(0, 0, 0, 0, 0); guess_ready_i = 0;
        check("xfer_word", guess_word_o, 0);
        check("xfer_cursor", cursor_o, 0);
        check("xfer_valid", guess_valid_o, 0);

        // Position 2 left blank.
        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        check("hole_word", guess_word_o, HOLE2);
        step(0, 0, 0, 0, 1);
        check("incomplete_hi", incomplete_o, 1);
        check("incomplete_valid", guess_valid_o, 0);
        check("incomplete_word", guess_word_o, HOLE2);
        step(0, 0, 0, 0, 0);
        check("incomplete_lo", incomplete_o, 0);

        enable_i = 0;
        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 1);
        check("en_low_word", guess_word_o, HOLE2);
        check("en_low_cursor", cursor_o, 4);
        check("en_low_incomplete", incomplete_o, 0);
        enable_i = 1;
        step(1, 1, 0, 0, 0);
        check("ud_same", cur_letter_o, 1);

        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        check("l_to_2", cursor_o, 2);
        step(1, 0, 0, 0, 0);
        check("full_word", guess_word_o, AAAAA);
        step(1, 0, 0, 0, 1);
        check("cu_valid", guess_valid_o, 1);
        check("cu_word", guess_word_o, AAAAA);

        guess_ready_i = 1; new_game_i = 1;
        step(0, 0, 0, 0, 0);
        new_game_i = 0;
        check("ng_xfer_valid", guess_valid_o, 0);
        check("ng_xfer_word", guess_word_o, 0);
        check("ng_xfer_incomplete", incomplete_o, 0);
        step(0, 0, 0, 0, 0);
        check("ready_idle_valid", guess_valid_o, 0);
        guess_ready_i = 0;

        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
        check("pre_rst_word", guess_word_o, 1 | (1 << 5));
        #3 rst_ni = 0;
        #1;
        check("async_word", guess_word_o, 0);
        check("async_cursor", cursor_o, 0);
        check("async_cur_letter", cur_letter_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
